// File: rtl/ahb_dma_write_master.sv
// ---------------------------------------------------------------------------
// ahb_dma_write_master
//
// AHB-Lite write-only bus master for the CPU/DMA path. A command (start
// address, word count, burst type) is accepted on the cmd_* handshake. Words
// are pulled from a local valid/ready source and written onto AHB-Lite as
// pipelined NONSEQ/SEQ/BUSY transfers. Wait states (HREADY=0) and two-cycle
// ERROR responses are honoured.
//
// Ports
//   HCLK, HRESET         clock, synchronous active-high reset
//   cmd_valid/ready      command handshake
//   cmd_addr             start byte address (bits [1:0] ignored)
//   cmd_len              number of 32-bit words (0 = complete immediately)
//   cmd_burst            SINGLE, INCR, INCR4, INCR8 or INCR16
//   src_data/valid       write data source
//   src_ready            pop strobe, high in the cycle a word is consumed
//   HADDR..HSIZE         AHB-Lite master address/control/write data
//   HREADY, HRESP        AHB-Lite slave response
//   busy                 command in progress or data phase outstanding
//   done, error          one-cycle completion pulses (OKAY / aborted)
// ---------------------------------------------------------------------------
package ahb_dma_pkg;
  typedef enum logic [2:0] {
    SINGLE = 3'b000, INCR   = 3'b001, WRAP4  = 3'b010, INCR4 = 3'b011,
    WRAP8  = 3'b100, INCR8  = 3'b101, WRAP16 = 3'b110, INCR16 = 3'b111
  } HBURST_Type;
  typedef enum logic [1:0] {
    IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11
  } HTRANS_state;
  typedef enum logic {
    OKAY = 1'b0, ERROR = 1'b1
  } HRESP_state;
endpackage

module ahb_dma_write_master
  import ahb_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  HBURST_Type       cmd_burst,
  input  logic [31:0]      src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [31:0]      HADDR,
  output logic [31:0]      HWDATA,
  output logic             HWRITE,
  output HBURST_Type       HBURST,
  output logic [2:0]       HSIZE,
  output HTRANS_state      HTRANS,
  input  logic             HREADY,
  input  HRESP_state       HRESP,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_BURST, ST_LAST_DATA, ST_ERR
  } state_t;

  // How the command is split into bursts.
  typedef enum logic [1:0] {
    M_SINGLE, M_INCR, M_FIXED
  } mode_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;          // address of the next beat
  logic [31:0]      hwdata_q, hwdata_d;
  HBURST_Type       hburst_q, hburst_d;      // burst type of the burst in flight
  logic [LEN_W-1:0] rem_q, rem_d;            // beats still to be issued
  logic [3:0]       beat_cnt_q, beat_cnt_d;  // beats left in a fixed burst
  mode_t            mode_q, mode_d;
  HBURST_Type       fixed_burst_q, fixed_burst_d;
  logic [3:0]       fixed_nm1_q, fixed_nm1_d;  // fixed burst length minus one
  logic             dphase_q, dphase_d;      // a data phase is outstanding
  logic             done_q, done_d;
  logic             error_q, error_d;

  HTRANS_state      htrans_c;
  HBURST_Type       hburst_c;
  HBURST_Type       start_burst;   // burst type if a new burst started now
  HBURST_Type       burst_kind;
  logic [3:0]       beat_left;
  logic [31:0]      next_addr;
  logic             accept;
  logic             bus_err;

  assign next_addr = addr_q + 32'd4;
  // First cycle of the two-cycle ERROR response on an outstanding data phase.
  assign bus_err   = dphase_q && !HREADY && (HRESP == ERROR);

  // A fixed-length command falls back to INCR for the tail shorter than N.
  always_comb begin
    start_burst = SINGLE;
    case (mode_q)
      M_SINGLE: start_burst = SINGLE;
      M_INCR:   start_burst = INCR;
      default:  start_burst = (rem_q > LEN_W'(fixed_nm1_q)) ? fixed_burst_q : INCR;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    hwdata_d      = hwdata_q;
    hburst_d      = hburst_q;
    rem_d         = rem_q;
    beat_cnt_d    = beat_cnt_q;
    mode_d        = mode_q;
    fixed_burst_d = fixed_burst_q;
    fixed_nm1_d   = fixed_nm1_q;
    dphase_d      = dphase_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    htrans_c      = IDLE;
    hburst_c      = hburst_q;
    burst_kind    = hburst_q;
    beat_left     = 4'd0;

    // Transfer type follows the source: no word means IDLE before a burst
    // has started and BUSY inside one.
    case (state_q)
      ST_ADDR: begin
        htrans_c = src_valid ? NONSEQ : IDLE;
        hburst_c = start_burst;
      end
      ST_BURST: htrans_c = src_valid ? SEQ : BUSY;
      default: ;
    endcase

    accept = HREADY && ((htrans_c == NONSEQ) || (htrans_c == SEQ));
    if (HREADY) dphase_d = accept;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && !dphase_q) begin
          addr_d        = cmd_addr & 32'hFFFF_FFFC;
          rem_d         = cmd_len;
          mode_d        = M_INCR;
          fixed_burst_d = INCR4;
          fixed_nm1_d   = 4'd3;
          case (cmd_burst)
            SINGLE: mode_d = M_SINGLE;
            INCR4:  if (cmd_addr[3:2] == 2'b00) mode_d = M_FIXED;
            INCR8:  begin
              if (cmd_addr[4:2] == 3'b000) mode_d = M_FIXED;
              fixed_burst_d = INCR8;
              fixed_nm1_d   = 4'd7;
            end
            INCR16: begin
              if (cmd_addr[5:2] == 4'b0000) mode_d = M_FIXED;
              fixed_burst_d = INCR16;
              fixed_nm1_d   = 4'd15;
            end
            default: mode_d = M_INCR;
          endcase
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ST_ADDR;
        end
      end

      ST_ADDR, ST_BURST: begin
        if (bus_err) begin
          state_d = ST_ERR;
        end else if (accept) begin
          hwdata_d = src_data;
          addr_d   = next_addr;
          rem_d    = rem_q - LEN_W'(1);
          if (state_q == ST_ADDR) begin
            hburst_d   = start_burst;
            burst_kind = start_burst;
            beat_left  = fixed_nm1_q;
          end else begin
            burst_kind = hburst_q;
            beat_left  = beat_cnt_q - 4'd1;
          end
          beat_cnt_d = beat_left;
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_LAST_DATA;
          end else begin
            case (burst_kind)
              SINGLE:  state_d = ST_ADDR;
              // Undefined-length bursts may not cross a 1 KB boundary.
              INCR:    state_d = (next_addr[9:0] == 10'd0) ? ST_ADDR : ST_BURST;
              default: state_d = (beat_left == 4'd0) ? ST_ADDR : ST_BURST;
            endcase
          end
        end
      end

      ST_LAST_DATA: begin
        if (bus_err) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ERR: begin
        // Second response cycle closes the errored data phase.
        if (HREADY) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      hwdata_q      <= '0;
      hburst_q      <= SINGLE;
      rem_q         <= '0;
      beat_cnt_q    <= '0;
      mode_q        <= M_SINGLE;
      fixed_burst_q <= INCR4;
      fixed_nm1_q   <= 4'd3;
      dphase_q      <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      hwdata_q      <= hwdata_d;
      hburst_q      <= hburst_d;
      rem_q         <= rem_d;
      beat_cnt_q    <= beat_cnt_d;
      mode_q        <= mode_d;
      fixed_burst_q <= fixed_burst_d;
      fixed_nm1_q   <= fixed_nm1_d;
      dphase_q      <= dphase_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign HTRANS    = htrans_c;
  assign HWRITE    = (htrans_c != IDLE);
  assign HADDR     = addr_q;
  assign HBURST    = hburst_c;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = 3'b010;
  assign src_ready = accept;
  assign cmd_ready = (state_q == ST_IDLE) && !dphase_q;
  assign busy      = (state_q != ST_IDLE) || dphase_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_ahb_dma_write_master.sv
module tb_ahb_dma_write_master;
  import ahb_dma_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  HBURST_Type  cmd_burst;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  HBURST_Type  HBURST;
  logic [2:0]  HSIZE;
  HTRANS_state HTRANS;
  logic        HREADY;
  HRESP_state  HRESP;
  logic        busy;
  logic        done;
  logic        error;

  always #5 HCLK = ~HCLK;

  ahb_dma_write_master #(.LEN_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HBURST(HBURST),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    HTRANS_state tr;
    HBURST_Type  bu;
  } addr_t;
  typedef struct {
    logic is_err;
    int   off;      // expected cycle offset from command issue, -1 = any
  } evt_t;

  addr_t       exp_addr[$];
  logic [31:0] exp_data[$];
  evt_t        exp_evt[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          cmd_cyc = 0;
  int          pops = 0;
  logic [31:0] src_idx = 32'd0;
  logic        pop_pend = 1'b0;
  logic        mon_en = 1'b0;

  assign src_data = 32'hC0DE_0000 + src_idx;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Source: advances to the next word after each pop.
  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      if (pop_pend) begin
        src_idx  = src_idx + 32'd1;
        pop_pend = 1'b0;
      end
    end
  end

  // Monitor: compares every completed address phase, data phase and
  // completion pulse against the queues filled by the stimulus.
  logic        dph = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_hready;
  logic        prev_err;
  HTRANS_state prev_tr;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;

  initial begin
    addr_t a;
    evt_t  e;
    forever begin
      @(negedge HCLK);
      if (mon_en) begin
        if (prev_valid && !prev_hready && prev_tr != IDLE && !prev_err) begin
          check("hold_haddr", HADDR, prev_addr);
          check("hold_htrans", 32'(HTRANS), 32'(prev_tr));
          check("hold_hwdata", HWDATA, prev_wdata);
        end
        if (HTRANS != IDLE && HREADY) begin
          if (exp_addr.size() == 0) begin
            check("addr_unexpected", HADDR, 32'hFFFF_FFFF);
          end else begin
            a = exp_addr.pop_front();
            $display("beat haddr=%08h htrans=%0d hburst=%0d", HADDR, HTRANS, HBURST);
            check("haddr", HADDR, a.addr);
            check("htrans", 32'(HTRANS), 32'(a.tr));
            check("hburst", 32'(HBURST), 32'(a.bu));
            check("hwrite", 32'(HWRITE), 32'd1);
          end
        end
        if (dph && HREADY) begin
          if (exp_data.size() == 0) check("hwdata_unexpected", HWDATA, 32'hFFFF_FFFF);
          else check("hwdata", HWDATA, exp_data.pop_front());
        end
        if (done || error) begin
          if (exp_evt.size() == 0) begin
            check("evt_unexpected", {30'd0, error, done}, 32'd0);
          end else begin
            e = exp_evt.pop_front();
            $display("event done=%0b error=%0b cycle=+%0d", done, error, cyc - cmd_cyc);
            check("evt_error", 32'(error), 32'(e.is_err));
            check("evt_done", 32'(done), 32'(!e.is_err));
            if (e.off >= 0) check("evt_cycle", 32'(cyc - cmd_cyc), 32'(e.off));
          end
        end
      end
      if (src_ready) begin
        pops++;
        pop_pend = 1'b1;
      end
      if (HRESET)      dph = 1'b0;
      else if (HREADY) dph = (HTRANS == NONSEQ) || (HTRANS == SEQ);
      prev_valid  = !HRESET;
      prev_hready = HREADY;
      prev_err    = (HRESP == ERROR);
      prev_tr     = HTRANS;
      prev_addr   = HADDR;
      prev_wdata  = HWDATA;
    end
  end

  task automatic push_addr(input logic [31:0] addr, input HTRANS_state tr, input HBURST_Type bu);
    addr_t a;
    a.addr = addr; a.tr = tr; a.bu = bu;
    exp_addr.push_back(a);
  endtask

  task automatic push_data(input int n);
    for (int k = 0; k < n; k++) exp_data.push_back(32'hC0DE_0000 + src_idx + 32'(k));
  endtask

  task automatic push_evt(input logic is_err, input int off);
    evt_t e;
    e.is_err = is_err; e.off = off;
    exp_evt.push_back(e);
  endtask

  // Issues one command, then drives 16 cycles of bus/source behaviour
  // from per-cycle masks (bit k applies to cycle k after issue).
  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] len, input HBURST_Type bt,
                         input logic [31:0] hr_low, input logic [31:0] sv_low,
                         input logic [31:0] err_m, input logic [31:0] rst_m,
                         input int chk_k, input int chk_kind);
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_burst = bt;
    @(negedge HCLK);
    check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    cmd_cyc = cyc;
    for (int k = 1; k <= 16; k++) begin
      @(posedge HCLK);
      #1;
      cmd_valid = 1'b0;
      HREADY    = ~hr_low[k];
      src_valid = ~sv_low[k];
      HRESP     = err_m[k] ? ERROR : OKAY;
      HRESET    = rst_m[k];
      if (k == chk_k) begin
        @(negedge HCLK);
        check("post_htrans_idle", 32'(HTRANS), 32'(IDLE));
        if (chk_kind == 2) check("post_reset_busy", 32'(busy), 32'd0);
      end
      if (chk_k > 0 && k == chk_k + 1) begin
        @(negedge HCLK);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
      end
    end
    HREADY = 1'b1; src_valid = 1'b1; HRESP = OKAY; HRESET = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int exp_pops, input int pops0);
    int n = 0;
    while ((exp_addr.size() + exp_data.size() + exp_evt.size()) != 0 && n < 40) begin
      @(negedge HCLK);
      n++;
    end
    repeat (2) @(negedge HCLK);
    check({name, "_drained"}, 32'(exp_addr.size() + exp_data.size() + exp_evt.size()), 32'd0);
    check({name, "_pops"}, 32'(pops - pops0), 32'(exp_pops));
    exp_addr.delete();
    exp_data.delete();
    exp_evt.delete();
  endtask

  initial begin
    int p0;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = SINGLE;
    src_valid = 1'b1; HREADY = 1'b1; HRESP = OKAY;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_htrans", 32'(HTRANS), 32'(IDLE));
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hburst", 32'(HBURST), 32'(SINGLE));
    check("rst_hsize", 32'(HSIZE), 32'd2);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    mon_en = 1'b1;

    // SINGLE, two beats, done four cycles after issue.
    p0 = pops; push_data(2); push_evt(1'b0, 4);
    push_addr(32'h100, NONSEQ, SINGLE); push_addr(32'h104, NONSEQ, SINGLE);
    run_cmd(32'h100, 16'd2, SINGLE, 0, 0, 0, 0, 0, 0);
    wait_drain("single", 2, p0);

    // INCR4 x6: one INCR4 then a two-beat INCR remainder.
    p0 = pops; push_data(6); push_evt(1'b0, 8);
    push_addr(32'h200, NONSEQ, INCR4); push_addr(32'h204, SEQ, INCR4);
    push_addr(32'h208, SEQ, INCR4);    push_addr(32'h20C, SEQ, INCR4);
    push_addr(32'h210, NONSEQ, INCR);  push_addr(32'h214, SEQ, INCR);
    run_cmd(32'h200, 16'd6, INCR4, 0, 0, 0, 0, 0, 0);
    wait_drain("incr4_rem", 6, p0);

    // INCR with the source stalled for two cycles on beat 3.
    p0 = pops; push_data(4); push_evt(1'b0, 8);
    push_addr(32'h000, NONSEQ, INCR); push_addr(32'h004, SEQ, INCR);
    push_addr(32'h008, BUSY, INCR);   push_addr(32'h008, BUSY, INCR);
    push_addr(32'h008, SEQ, INCR);    push_addr(32'h00C, SEQ, INCR);
    run_cmd(32'h000, 16'd4, INCR, 0, 32'h18, 0, 0, 0, 0);
    wait_drain("incr_busy", 4, p0);

    // INCR across a 1 KB boundary restarts with NONSEQ.
    p0 = pops; push_data(4); push_evt(1'b0, -1);
    push_addr(32'h3F8, NONSEQ, INCR); push_addr(32'h3FC, SEQ, INCR);
    push_addr(32'h400, NONSEQ, INCR); push_addr(32'h404, SEQ, INCR);
    run_cmd(32'h3F8, 16'd4, INCR, 0, 0, 0, 0, 0, 0);
    wait_drain("incr_1k", 4, p0);

    // INCR8 with three wait states on beat 2.
    p0 = pops; push_data(8); push_evt(1'b0, 13);
    push_addr(32'h000, NONSEQ, INCR8);
    for (int k = 1; k < 8; k++) push_addr(32'(4 * k), SEQ, INCR8);
    run_cmd(32'h000, 16'd8, INCR8, 32'h1C, 0, 0, 0, 0, 0);
    wait_drain("incr8_wait", 8, p0);

    // Unaligned INCR4 is issued entirely as INCR.
    p0 = pops; push_data(3); push_evt(1'b0, -1);
    push_addr(32'h104, NONSEQ, INCR); push_addr(32'h108, SEQ, INCR);
    push_addr(32'h10C, SEQ, INCR);
    run_cmd(32'h106, 16'd3, INCR4, 0, 0, 0, 0, 0, 0);
    wait_drain("incr4_unal", 3, p0);

    // Zero-length command completes next cycle with no transfers.
    p0 = pops; push_evt(1'b0, 1);
    run_cmd(32'h080, 16'd0, INCR, 0, 0, 0, 0, 0, 0);
    wait_drain("len0", 0, p0);

    // ERROR on beat 2 of INCR4: bus goes IDLE, error pulse, no done.
    p0 = pops; push_data(2); push_evt(1'b1, 5);
    push_addr(32'h040, NONSEQ, INCR4); push_addr(32'h044, SEQ, INCR4);
    run_cmd(32'h040, 16'd4, INCR4, 32'h08, 0, 32'h18, 0, 4, 1);
    wait_drain("error", 2, p0);

    // Reset in the middle of a burst: IDLE after the edge, no pulses.
    p0 = pops; push_data(2);
    push_addr(32'h500, NONSEQ, INCR); push_addr(32'h504, SEQ, INCR);
    push_addr(32'h508, SEQ, INCR);
    run_cmd(32'h500, 16'd8, INCR, 0, 0, 0, 32'h08, 4, 2);
    wait_drain("reset_mid", 3, p0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
